// File: rtl/external_config_interface.sv
// external_config_interface
// UART configuration port between an external FPGA and the analog core's
// register file. 18-bit packets arrive on i_posi (start, 18 data bits LSB
// first, stop). Each packet either writes one 8-bit register or reads one
// back; read responses leave on o_piso in the same frame format.
// Optional feature: define WRITE_ECHO_EN to echo every accepted write on
// o_piso as {parity, addr, data, 1'b0}.
`timescale 1ns/1ps

module external_config_interface #(
  parameter int NUMREGS      = 9,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_posi,
  output logic       o_piso,
  output logic [7:0] o_config_bits [NUMREGS]
);

  localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [4:0]        BIT_LAST = 5'd17;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rxState_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} txState_t;

  // Input synchroniser
  logic             r_posiMeta;
  logic             r_posiSync;

  // Receiver
  rxState_t         r_rxState, w_rxStateNext;
  logic [CNT_W-1:0] r_rxCnt, w_rxCntNext;
  logic [4:0]       r_rxBit, w_rxBitNext;
  logic [17:0]      r_rxShift, w_rxShiftNext;
  logic             r_rxErr, w_rxErrNext;
  logic             r_rxValid, w_rxValidNext;

  // Command decode
  logic             w_wrb;
  logic [7:0]       w_data;
  logic [7:0]       w_addr;
  logic             w_parityOk;
  logic             w_addrOk;
  logic             w_doWrite;
  logic             w_doRead;
  logic             w_echoWrite;
  logic             w_loadResp;
  logic [7:0]       w_readData;
  logic [16:0]      w_respBody;
  logic [17:0]      w_resp;

  // Register file
  logic [7:0]       r_regs [NUMREGS];

  // Transmit buffer and transmitter
  logic [17:0]      r_txBuf;
  logic             r_txPending;
  logic             w_txTake;
  txState_t         r_txState, w_txStateNext;
  logic [CNT_W-1:0] r_txCnt, w_txCntNext;
  logic [4:0]       r_txBit, w_txBitNext;
  logic [17:0]      r_txShift, w_txShiftNext;
  logic             r_piso, w_pisoNext;

  // Two-flop synchroniser for the asynchronous serial input (idles high)
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_posiMeta <= 1'b1;
      r_posiSync <= 1'b1;
    end else begin
      r_posiMeta <= i_posi;
      r_posiSync <= r_posiMeta;
    end
  end

  // RX state register
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_rxState <= RX_IDLE;
      r_rxCnt   <= '0;
      r_rxBit   <= '0;
      r_rxShift <= '0;
      r_rxErr   <= 1'b0;
      r_rxValid <= 1'b0;
    end else begin
      r_rxState <= w_rxStateNext;
      r_rxCnt   <= w_rxCntNext;
      r_rxBit   <= w_rxBitNext;
      r_rxShift <= w_rxShiftNext;
      r_rxErr   <= w_rxErrNext;
      r_rxValid <= w_rxValidNext;
    end
  end

  // RX next state: half-bit start check rejects runts, mid-bit sampling after that
  always_comb begin
    w_rxStateNext = r_rxState;
    w_rxCntNext   = r_rxCnt;
    w_rxBitNext   = r_rxBit;
    w_rxShiftNext = r_rxShift;
    w_rxErrNext   = r_rxErr;
    w_rxValidNext = 1'b0;
    case (r_rxState)
      RX_IDLE: begin
        w_rxErrNext = 1'b0;
        if (!r_posiSync) begin
          w_rxStateNext = RX_START;
          w_rxCntNext   = '0;
        end
      end
      RX_START: begin
        if (r_rxCnt == CNT_HALF) begin
          w_rxCntNext = '0;
          w_rxBitNext = '0;
          if (r_posiSync) w_rxStateNext = RX_IDLE;
          else            w_rxStateNext = RX_DATA;
        end else begin
          w_rxCntNext = r_rxCnt + 1'b1;
        end
      end
      RX_DATA: begin
        if (r_rxCnt == CNT_LAST) begin
          w_rxCntNext   = '0;
          w_rxShiftNext = {r_posiSync, r_rxShift[17:1]};
          if (r_rxBit == BIT_LAST) w_rxStateNext = RX_STOP;
          else                     w_rxBitNext   = r_rxBit + 1'b1;
        end else begin
          w_rxCntNext = r_rxCnt + 1'b1;
        end
      end
      RX_STOP: begin
        if (r_rxErr) begin
          if (r_posiSync) w_rxStateNext = RX_IDLE;
        end else if (r_rxCnt == CNT_LAST) begin
          if (r_posiSync) begin
            w_rxValidNext = 1'b1;
            w_rxStateNext = RX_IDLE;
          end else begin
            w_rxErrNext = 1'b1;
          end
        end else begin
          w_rxCntNext = r_rxCnt + 1'b1;
        end
      end
      default: w_rxStateNext = RX_IDLE;
    endcase
  end

  assign w_wrb      = r_rxShift[0];
  assign w_data     = r_rxShift[8:1];
  assign w_addr     = r_rxShift[16:9];
  assign w_parityOk = ^r_rxShift;
  assign w_addrOk   = (w_addr < 8'(NUMREGS));
  assign w_doWrite  = r_rxValid & w_parityOk & ~w_wrb & w_addrOk;
  assign w_doRead   = r_rxValid & w_parityOk & w_wrb;

`ifdef WRITE_ECHO_EN
  assign w_echoWrite = w_doWrite;
`else
  assign w_echoWrite = 1'b0;
`endif

  assign w_loadResp = w_doRead | w_echoWrite;

  // Read mux; addresses outside the register file read back as zero
  always_comb begin
    w_readData = 8'h00;
    for (int i = 0; i < NUMREGS; i++) begin
      if (w_addr == 8'(i)) w_readData = r_regs[i];
    end
  end

  // Response packet with odd parity over all 18 bits
  always_comb begin
    w_respBody = '0;
    if (w_wrb) w_respBody = {w_addr, w_readData, 1'b1};
    else       w_respBody = {w_addr, w_data, 1'b0};
    w_resp = {~(^w_respBody), w_respBody};
  end

  // Register file write port
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < NUMREGS; i++) r_regs[i] <= 8'h00;
    end else begin
      for (int i = 0; i < NUMREGS; i++) begin
        if (w_doWrite && (w_addr == 8'(i))) r_regs[i] <= w_data;
      end
    end
  end

  assign o_config_bits = r_regs;

  // Single-entry response buffer; a newer response overwrites a pending one
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_txBuf     <= '0;
      r_txPending <= 1'b0;
    end else if (w_loadResp) begin
      r_txBuf     <= w_resp;
      r_txPending <= 1'b1;
    end else if (w_txTake) begin
      r_txPending <= 1'b0;
    end
  end

  // TX state register, including the registered serial output
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_txState <= TX_IDLE;
      r_txCnt   <= '0;
      r_txBit   <= '0;
      r_txShift <= '0;
      r_piso    <= 1'b1;
    end else begin
      r_txState <= w_txStateNext;
      r_txCnt   <= w_txCntNext;
      r_txBit   <= w_txBitNext;
      r_txShift <= w_txShiftNext;
      r_piso    <= w_pisoNext;
    end
  end

  // TX next state: line level changes only on bit-period boundaries
  always_comb begin
    w_txStateNext = r_txState;
    w_txCntNext   = r_txCnt;
    w_txBitNext   = r_txBit;
    w_txShiftNext = r_txShift;
    w_pisoNext    = r_piso;
    w_txTake      = 1'b0;
    case (r_txState)
      TX_IDLE: begin
        w_pisoNext = 1'b1;
        if (r_txPending) begin
          w_txTake      = 1'b1;
          w_txStateNext = TX_START;
          w_txCntNext   = '0;
          w_txShiftNext = r_txBuf;
          w_pisoNext    = 1'b0;
        end
      end
      TX_START: begin
        if (r_txCnt == CNT_LAST) begin
          w_txStateNext = TX_DATA;
          w_txCntNext   = '0;
          w_txBitNext   = '0;
          w_pisoNext    = r_txShift[0];
        end else begin
          w_txCntNext = r_txCnt + 1'b1;
        end
      end
      TX_DATA: begin
        if (r_txCnt == CNT_LAST) begin
          w_txCntNext = '0;
          if (r_txBit == BIT_LAST) begin
            w_txStateNext = TX_STOP;
            w_pisoNext    = 1'b1;
          end else begin
            w_txBitNext   = r_txBit + 1'b1;
            w_txShiftNext = {1'b0, r_txShift[17:1]};
            w_pisoNext    = r_txShift[1];
          end
        end else begin
          w_txCntNext = r_txCnt + 1'b1;
        end
      end
      TX_STOP: begin
        if (r_txCnt == CNT_LAST) begin
          w_txStateNext = TX_IDLE;
          w_txCntNext   = '0;
          w_pisoNext    = 1'b1;
        end else begin
          w_txCntNext = r_txCnt + 1'b1;
        end
      end
      default: w_txStateNext = TX_IDLE;
    endcase
  end

  assign o_piso = r_piso;

endmodule

// File: tb/tb_external_config_interface.sv
// Testbench for external_config_interface: drives UART packets on posi,
// captures frames from piso and checks them and config_bits against a
// register-array model.
`timescale 1ns/1ps

module tb_external_config_interface;

  localparam int NUMREGS      = 9;
  localparam int CLKS_PER_BIT = 16;
  localparam int FRAME_CYCLES = 20 * CLKS_PER_BIT;
`ifdef WRITE_ECHO_EN
  localparam bit ECHO = 1'b1;
`else
  localparam bit ECHO = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       resetN;
  logic       posi;
  logic       piso;
  logic [7:0] configBits [NUMREGS];

  int          testsRun = 0;
  int          testsFailed = 0;
  int          lowCount = 0;
  logic [7:0]  model [NUMREGS];
  logic [18:0] expQ [$];
  logic [18:0] gotQ [$];

  // 100 MHz system clock
  always #5 clk = ~clk;

  external_config_interface #(
    .NUMREGS      (NUMREGS),
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) dut (
    .i_clk         (clk),
    .i_reset_n     (resetN),
    .i_posi        (posi),
    .o_piso        (piso),
    .o_config_bits (configBits)
  );

  // Count every low sample on piso so silent periods can be verified
  always @(negedge clk) begin
    if (piso === 1'b0) lowCount = lowCount + 1;
  end

  // Capture piso frames as {stop, packet[17:0]}, sampled mid-bit
  initial begin : frameMonitor
    logic [18:0] frame;
    frame = '0;
    forever begin
      @(negedge clk);
      if (resetN === 1'b1 && piso === 1'b0) begin
        repeat (CLKS_PER_BIT / 2) @(negedge clk);
        if (piso === 1'b0) begin
          for (int b = 0; b < 19; b++) begin
            repeat (CLKS_PER_BIT) @(negedge clk);
            frame[b] = piso;
          end
          gotQ.push_back(frame);
        end
      end
    end
  end

  // Build a packet whose 18 bits have odd parity, optionally corrupted
  function automatic logic [17:0] makePacket(input logic wrb, input logic [7:0] addr,
                                             input logic [7:0] data, input logic flip);
    logic [16:0] body;
    logic        par;
    body = {addr, data, wrb};
    par  = (($countones(body) % 2) == 0);
    return {par ^ flip, body};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Serialise one packet on posi; called aligned to a falling clock edge
  task automatic applyStimulus(input logic [17:0] pkt);
    posi = 1'b0;
    repeat (CLKS_PER_BIT) @(negedge clk);
    for (int b = 0; b < 18; b++) begin
      posi = pkt[b];
      repeat (CLKS_PER_BIT) @(negedge clk);
    end
    posi = 1'b1;
    repeat (CLKS_PER_BIT) @(negedge clk);
  endtask

  task automatic sendWrite(input logic [7:0] addr, input logic [7:0] data, input logic flip);
    applyStimulus(makePacket(1'b0, addr, data, flip));
    if (!flip && addr < NUMREGS) begin
      model[addr] = data;
      if (ECHO) expQ.push_back({1'b1, makePacket(1'b0, addr, data, 1'b0)});
    end
  endtask

  task automatic sendRead(input logic [7:0] addr, input logic flip);
    logic [7:0] expData;
    applyStimulus(makePacket(1'b1, addr, 8'h00, flip));
    expData = (addr < NUMREGS) ? model[addr] : 8'h00;
    if (!flip) expQ.push_back({1'b1, makePacket(1'b1, addr, expData, 1'b0)});
  endtask

  task automatic checkRegs(input string tag);
    for (int i = 0; i < NUMREGS; i++)
      checkOutput($sformatf("%s reg%0d", tag, i), 32'(configBits[i]), 32'(model[i]));
  endtask

  // Wait (bounded) for all expected frames, then compare them in order
  task automatic drainFrames(input string tag);
    for (int i = 0; i < 3 * FRAME_CYCLES && gotQ.size() < expQ.size(); i++) @(negedge clk);
    checkOutput($sformatf("%s frame count", tag), gotQ.size(), expQ.size());
    while (gotQ.size() > 0 && expQ.size() > 0)
      checkOutput($sformatf("%s frame", tag), 32'(gotQ.pop_front()), 32'(expQ.pop_front()));
    gotQ.delete();
    expQ.delete();
  endtask

  initial begin
    logic [7:0] a;
    logic [7:0] d;
    int         lowBefore;

    posi   = 1'b1;
    resetN = 1'b0;
    for (int i = 0; i < NUMREGS; i++) model[i] = 8'h00;
    repeat (5) @(negedge clk);
    checkOutput("reset piso", 32'(piso), 32'd1);
    checkRegs("reset");
    resetN = 1'b1;

    repeat (100) @(negedge clk);
    checkOutput("idle piso low samples", lowCount, 0);
    checkOutput("idle piso", 32'(piso), 32'd1);

    sendWrite(8'h01, 8'hAB, 1'b0);
    checkRegs("write1");
    sendRead(8'h01, 1'b0);
    drainFrames("read1");

    sendWrite(8'h02, 8'h77, 1'b1);
    sendWrite(8'h0C, 8'h55, 1'b0);
    checkRegs("rejected writes");
    sendRead(8'h0C, 1'b0);
    sendRead(8'h01, 1'b1);
    drainFrames("out-of-range read");

    lowBefore = lowCount;
    @(negedge clk);
    #2 posi = 1'b0;
    #15 posi = 1'b1;
    @(negedge clk);
    repeat (60) @(negedge clk);
    checkOutput("runt piso activity", lowCount - lowBefore, 0);
    checkRegs("runt");
    sendWrite(8'h03, 8'h5A, 1'b0);
    checkOutput("post-runt reg3", 32'(configBits[3]), 32'h5A);
    drainFrames("post-runt");

    for (int n = 0; n < 100; n++) begin
      a = 8'($urandom_range(0, NUMREGS - 1));
      d = 8'($urandom_range(0, 255));
      sendWrite(a, d, 1'b0);
      checkOutput($sformatf("random write reg%0d", a), 32'(configBits[a]), 32'(d));
      sendRead(a, 1'b0);
    end
    drainFrames("random reads");
    checkRegs("final");
    repeat (50) @(negedge clk);
    checkOutput("final piso idle", 32'(piso), 32'd1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
